// File: rtl/seg7_capture.sv
// seg7_capture: receive side of the 6-digit multiplexed seven-segment bus; rebuilds the
// 24-bit word and publishes it once stable. Define SEG7_CAP_DP_EN to also capture decimal points on dp_out.
module seg7_capture #(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk_1khz,
  input  logic        rst_n,
  input  logic [2:0]  sel_in,
  input  logic [7:0]  seg_in,
  output logic [23:0] data_out,
  output logic        data_valid,
  output logic        seq_err,
  output logic        pat_err
`ifdef SEG7_CAP_DP_EN
  ,
  output logic [5:0]  dp_out
`endif
);

`ifdef SEG7_CAP_DP_EN
  localparam int FW = 30;
`else
  localparam int FW = 24;
`endif
  localparam logic [2:0] SF = 3'(STABLE_FRAMES);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  // Returns {legal, nibble} for an active-low {g,f,e,d,c,b,a} glyph.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  state_t         state_r, state_s;
  logic [2:0]     exp_idx_r, exp_idx_s;
  logic [2:0]     match_cnt_r, match_cnt_s;
  logic [FW-1:0]  prev_frame_r, prev_frame_s;
  logic [FW-1:0]  shadow_r, shadow_s;
  logic [FW-1:0]  pub_r, pub_s;
  logic           have_pub_r, have_pub_s;
  logic           data_valid_r, data_valid_s;
  logic           seq_err_r, seq_err_s;
  logic           pat_err_r, pat_err_s;

  logic [4:0]     dec_s;
  logic           legal_s;
  logic [3:0]     nib_s;
  logic [FW-1:0]  frame_s;
  logic [2:0]     match_inc_s;

  assign dec_s       = seg_decode(seg_in[6:0]);
  assign legal_s     = dec_s[4];
  assign nib_s       = dec_s[3:0];
  assign match_inc_s = (match_cnt_r >= SF) ? SF : match_cnt_r + 3'd1;

`ifdef SEG7_CAP_DP_EN
  logic dp_lit_s;
  assign dp_lit_s = ~seg_in[7];
`else
  logic unused_dp_s;
  assign unused_dp_s = seg_in[7];
`endif

  // Shadow word with the digit currently on the bus merged in at its slot.
  always_comb begin
    frame_s = shadow_r;
    for (int i = 0; i < 6; i++) begin
      frame_s[23-4*i -: 4] = (sel_in == 3'(i)) ? nib_s : shadow_r[23-4*i -: 4];
`ifdef SEG7_CAP_DP_EN
      frame_s[29-i] = (sel_in == 3'(i)) ? dp_lit_s : shadow_r[29-i];
`endif
    end
  end

  // Next-state, frame qualification and pulse generation.
  always_comb begin
    state_s      = state_r;
    exp_idx_s    = exp_idx_r;
    match_cnt_s  = match_cnt_r;
    prev_frame_s = prev_frame_r;
    shadow_s     = shadow_r;
    pub_s        = pub_r;
    have_pub_s   = have_pub_r;
    data_valid_s = 1'b0;
    seq_err_s    = 1'b0;
    pat_err_s    = 1'b0;
    case (state_r)
      HUNT: begin
        if (sel_in == 3'd0) begin
          if (legal_s) begin
            shadow_s  = frame_s;
            exp_idx_s = 3'd1;
            state_s   = CAPTURE;
          end else begin
            pat_err_s = 1'b1;
          end
        end else begin
          state_s = HUNT;
        end
      end
      CAPTURE: begin
        if (!legal_s) begin
          // a bad glyph outranks an ordering error on the same sample
          pat_err_s   = 1'b1;
          match_cnt_s = 3'd0;
          exp_idx_s   = 3'd0;
          state_s     = HUNT;
        end else if (sel_in == exp_idx_r) begin
          shadow_s = frame_s;
          if (exp_idx_r == 3'd5) begin
            exp_idx_s    = 3'd0;
            state_s      = HUNT;
            prev_frame_s = frame_s;
            match_cnt_s  = (frame_s == prev_frame_r) ? match_inc_s : 3'd1;
            if ((match_cnt_s == SF) && (!have_pub_r || (frame_s != pub_r))) begin
              pub_s        = frame_s;
              have_pub_s   = 1'b1;
              data_valid_s = 1'b1;
            end else begin
              data_valid_s = 1'b0;
            end
          end else begin
            exp_idx_s = exp_idx_r + 3'd1;
          end
        end else begin
          seq_err_s   = 1'b1;
          match_cnt_s = 3'd0;
          if (sel_in == 3'd0) begin
            shadow_s  = frame_s;
            exp_idx_s = 3'd1;
            state_s   = CAPTURE;
          end else begin
            exp_idx_s = 3'd0;
            state_s   = HUNT;
          end
        end
      end
      default: begin
        state_s   = HUNT;
        exp_idx_s = 3'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= HUNT;
      exp_idx_r    <= 3'd0;
      match_cnt_r  <= 3'd0;
      prev_frame_r <= '0;
      shadow_r     <= '0;
      pub_r        <= '0;
      have_pub_r   <= 1'b0;
      data_valid_r <= 1'b0;
      seq_err_r    <= 1'b0;
      pat_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      exp_idx_r    <= exp_idx_s;
      match_cnt_r  <= match_cnt_s;
      prev_frame_r <= prev_frame_s;
      shadow_r     <= shadow_s;
      pub_r        <= pub_s;
      have_pub_r   <= have_pub_s;
      data_valid_r <= data_valid_s;
      seq_err_r    <= seq_err_s;
      pat_err_r    <= pat_err_s;
    end
  end

  assign data_out   = pub_r[23:0];
  assign data_valid = data_valid_r;
  assign seq_err    = seq_err_r;
  assign pat_err    = pat_err_r;
`ifdef SEG7_CAP_DP_EN
  assign dp_out     = pub_r[29:24];
`endif

endmodule
